cmp_max_tracker: RTL and testbench

- Sequential controller that feeds the 6-bit ripple magnitude comparator and consumes its greater/equal outputs.
- Accepts a stream of unsigned samples over a valid/ready handshake and drives the comparator operands: A = candidate sample, B = current running maximum.
- Registers the comparator verdict and maintains the running maximum, the index of the maximum, and a tie count.
- The comparator stays external and purely combinational; this block owns all state.

---
 rtl/cmp_max_tracker.sv | 160 ++++++++++++++++
 tb/tb_cmp_max_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_max_tracker.sv
// Running-maximum tracker that drives an external W-bit magnitude comparator.
// Optional macro CMP_SELF_CHECK_EN adds an internal cross-check of cmp_g/cmp_e.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high. in_data and in_last are only looked at on that edge.
// in_ready is high only in WAIT_IN and depends on state alone, never on in_valid.
module cmp_max_tracker #(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [W-1:0]     cmp_a,
    output logic [W-1:0]     cmp_b,
    input  logic             cmp_g,
    input  logic             cmp_e,
    output logic [W-1:0]     max_out,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] eq_count,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             cmp_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [W-1:0]     cand, max_r;
    logic [CNT_W-1:0] idx_r, eq_r, count, cur_idx;
    logic             first, last_r, ovf_r;
    logic             restart, accept, eval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        restart   = 1'b0;
        accept    = 1'b0;
        eval      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                busy      = 1'b1;
                eval      = 1'b1;
                state_nxt = last_r ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = S_WAIT_IN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are taken from registers only, so the comparator sees stable
    // values for the whole EVAL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand    <= '0;
            max_r   <= '0;
            idx_r   <= '0;
            eq_r    <= '0;
            count   <= '0;
            cur_idx <= '0;
            first   <= 1'b0;
            last_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (restart) begin
            max_r <= '0;
            idx_r <= '0;
            eq_r  <= '0;
            count <= '0;
            ovf_r <= 1'b0;
            first <= 1'b1;
        end else if (accept) begin
            cand    <= in_data;
            last_r  <= in_last;
            cur_idx <= count;
            if (count == CNT_MAX) ovf_r <= 1'b1;
            else                  count <= count + 1'b1;
        end else if (eval) begin
            if (first) begin
                max_r <= cand;
                idx_r <= cur_idx;
                first <= 1'b0;
            end else if (cmp_g) begin
                max_r <= cand;
                idx_r <= cur_idx;
            end else if (cmp_e && (eq_r != CNT_MAX)) begin
                // A tie only counts; the earliest index is kept.
                eq_r <= eq_r + 1'b1;
            end
        end
    end

`ifdef CMP_SELF_CHECK_EN
    logic err_r, chk_g, chk_e;

    assign chk_g = (cand > max_r);
    assign chk_e = (cand == max_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_r <= 1'b0;
        else if (restart)
            err_r <= 1'b0;
        else if (eval && !first && ((chk_g != cmp_g) || (chk_e != cmp_e)))
            err_r <= 1'b1;
    end

    assign cmp_err = err_r;
`else
    assign cmp_err = 1'b0;
`endif

    assign cmp_a     = cand;
    assign cmp_b     = max_r;
    assign max_out   = max_r;
    assign max_idx   = idx_r;
    assign eq_count  = eq_r;
    assign ovf       = ovf_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_cmp_max_tracker.sv
// Directed bench for cmp_max_tracker with a behavioural comparator attached.
// Stream vectors come from a table; reset and comparator-fault cases are hand-written.
module tb_cmp_max_tracker;

    localparam int W     = 6;
    localparam int CNT_W = 8;

    logic             clk, rst, start, in_valid, in_last;
    logic [W-1:0]     in_data;
    logic             in_ready, cmp_g, cmp_e, busy, done, ovf, cmp_err;
    logic [W-1:0]     cmp_a, cmp_b, max_out;
    logic [CNT_W-1:0] max_idx, eq_count;
    logic [1:0]       dbg_state;
    logic             force_g0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    // Reference comparator; force_g0 models a stuck-at-0 greater flag.
    assign cmp_g = force_g0 ? 1'b0 : (cmp_a > cmp_b);
    assign cmp_e = (cmp_a == cmp_b);

    cmp_max_tracker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_e(cmp_e),
        .max_out(max_out), .max_idx(max_idx), .eq_count(eq_count),
        .busy(busy), .done(done), .ovf(ovf), .cmp_err(cmp_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0][W-1:0] s;
        int                n;
        int                gap;
        logic              start_busy;
        logic [W-1:0]      exp_max;
        logic [CNT_W-1:0]  exp_idx;
        logic [CNT_W-1:0]  exp_eq;
        int                exp_first_lat;   // -1: not checked
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: expected values are queued ahead and popped at compare time
    task automatic sb_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got %0d", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // driver tasks: called and return at a negedge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last, output int hs);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        hs = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: done got 0 expected 1");
        end
        at = cyc;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int hs, first_hs, at;
        first_hs = 0;
        hs       = 0;
        pulse_start();
        for (int i = 0; i < v.n; i++) begin
            for (int g = 0; g < ((i == 0) ? 0 : v.gap); g++) begin
                start = (v.start_busy && i == 1 && g == 0);
                @(negedge clk);
                start = 1'b0;
            end
            send(v.s[i], (i == v.n - 1), hs);
            if (i == 0) first_hs = hs;
        end
        wait_done(at);
        exp_q.push_back(32'(v.exp_max));
        exp_q.push_back(32'(v.exp_idx));
        exp_q.push_back(32'(v.exp_eq));
        sb_check($sformatf("v%0d_max_out", k), 32'(max_out));
        sb_check($sformatf("v%0d_max_idx", k), 32'(max_idx));
        sb_check($sformatf("v%0d_eq_count", k), 32'(eq_count));
        check($sformatf("v%0d_last_lat", k), 32'(at - hs), 32'd2);
        if (v.exp_first_lat >= 0)
            check($sformatf("v%0d_first_lat", k), 32'(at - first_hs), 32'(v.exp_first_lat));
        check($sformatf("v%0d_ovf", k), 32'(ovf), 32'd0);
        // results must hold while in DONE
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_hold_max", k), 32'(max_out), 32'(v.exp_max));
        check($sformatf("v%0d_hold_done", k), 32'(done), 32'd1);
    endtask

    initial begin
        int hs;
        tbl[0] = '{s: {6'd0, 6'd63, 6'd3, 6'd17, 6'd5}, n: 5, gap: 0, start_busy: 1'b0,
                   exp_max: 6'd63, exp_idx: 8'd3, exp_eq: 8'd0, exp_first_lat: 10};
        tbl[1] = '{s: {6'd0, 6'd0, 6'd9, 6'd9, 6'd9}, n: 3, gap: 0, start_busy: 1'b0,
                   exp_max: 6'd9, exp_idx: 8'd0, exp_eq: 8'd2, exp_first_lat: -1};
        tbl[2] = '{s: {6'd0, 6'd1, 6'd12, 6'd12, 6'd4}, n: 4, gap: 0, start_busy: 1'b0,
                   exp_max: 6'd12, exp_idx: 8'd1, exp_eq: 8'd1, exp_first_lat: -1};
        tbl[3] = '{s: {6'd0, 6'd0, 6'd0, 6'd0, 6'd42}, n: 1, gap: 0, start_busy: 1'b0,
                   exp_max: 6'd42, exp_idx: 8'd0, exp_eq: 8'd0, exp_first_lat: 2};
        tbl[4] = '{s: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, n: 2, gap: 0, start_busy: 1'b0,
                   exp_max: 6'd0, exp_idx: 8'd0, exp_eq: 8'd1, exp_first_lat: -1};
        tbl[5] = '{s: {6'd0, 6'd63, 6'd3, 6'd17, 6'd5}, n: 5, gap: 3, start_busy: 1'b1,
                   exp_max: 6'd63, exp_idx: 8'd3, exp_eq: 8'd0, exp_first_lat: -1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; force_g0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_max_out", 32'(max_out), 32'd0);
        check("rst_eq_count", 32'(eq_count), 32'd0);
        check("rst_cmp_err", 32'(cmp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        for (int k = 0; k < 6; k++) run_vec(tbl[k], k);

        // asynchronous reset while evaluating the second sample
        pulse_start();
        send(6'd1, 1'b0, hs);
        send(6'd50, 1'b0, hs);
        check("pre_rst_state_eval", 32'(dbg_state), 32'd2);
        check("pre_rst_max_out", 32'(max_out), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_max_out", 32'(max_out), 32'd0);
        check("arst_cmp_a", 32'(cmp_a), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_state_idle", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // faulty comparator: greater flag stuck low
        force_g0 = 1'b1;
        pulse_start();
        send(6'd1, 1'b0, hs);
        send(6'd50, 1'b1, hs);
        wait_done(hs);
        check("fault_max_out", 32'(max_out), 32'd1);
        check("fault_max_idx", 32'(max_idx), 32'd0);
`ifdef CMP_SELF_CHECK_EN
        check("fault_cmp_err", 32'(cmp_err), 32'd1);
`else
        check("fault_cmp_err", 32'(cmp_err), 32'd0);
`endif
        force_g0 = 1'b0;
        pulse_start();
        check("restart_cmp_err", 32'(cmp_err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
